// File: rtl/vedic_mult_8x8_if.sv
// Operand/product bundle for the 8x8 Vedic multiplier.
// The master presents operands each cycle; the slave returns the registered product.
interface vedic_mult_8x8_if;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] prod;

  modport master (output a, output b, input prod);
  modport slave  (input a, input b, output prod);
endinterface

// File: rtl/vedic_mult_8x8.sv
// Unsigned 8x8 -> 16 multiplier using the Urdhva-Tiryagbhyam decomposition
// (2x2 -> 4x4 -> 8x8 cells), with a single output register.

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic c1;

  // Crosswise pair through one half adder, then vertical term plus that carry.
  assign p[0] = a[0] & b[0];
  assign p[1] = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign c1   = (a[1] & b[0]) & (a[0] & b[1]);
  assign p[2] = (a[1] & b[1]) ^ c1;
  assign p[3] = (a[1] & b[1]) & c1;
endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] ll, lh, hl, hh;
  logic [4:0] mid;
  logic [3:0] upper;

  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(ll));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(lh));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(hl));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(hh));

  // Middle sum is one bit wider than its operands so no carry is dropped;
  // everything above its low two bits feeds the upper adder.
  assign mid   = {1'b0, lh} + {1'b0, hl} + {3'b000, ll[3:2]};
  assign upper = hh + {1'b0, mid[4:2]};
  assign p     = {upper, mid[1:0], ll[1:0]};
endmodule

module vedic_8x8_core (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] ll, lh, hl, hh;
  logic [8:0] mid;
  logic [7:0] upper;

  vedic_4x4 u_ll (.a(a[3:0]), .b(b[3:0]), .p(ll));
  vedic_4x4 u_lh (.a(a[3:0]), .b(b[7:4]), .p(lh));
  vedic_4x4 u_hl (.a(a[7:4]), .b(b[3:0]), .p(hl));
  vedic_4x4 u_hh (.a(a[7:4]), .b(b[7:4]), .p(hh));

  assign mid   = {1'b0, lh} + {1'b0, hl} + {5'b00000, ll[7:4]};
  assign upper = hh + {3'b000, mid[8:4]};
  assign p     = {upper, mid[3:0], ll[3:0]};
endmodule

module vedic_mult_8x8 (
  input  logic             clk,
  input  logic             rst_n,
  vedic_mult_8x8_if.slave  bus
);
  logic [15:0] prod_comb;
  logic [15:0] prod_q;

  vedic_8x8_core u_core (.a(bus.a), .b(bus.b), .p(prod_comb));

  // NOTE: registered state uses non-blocking assignment so every flop samples
  // pre-edge values; the async clear makes a mid-cycle reset visible at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prod_q <= 16'h0000;
    else        prod_q <= prod_comb;
  end

  assign bus.prod = prod_q;
endmodule

// File: tb/tb_vedic_mult_8x8.sv
// Self-checking bench for vedic_mult_8x8: directed corners, throughput,
// async reset and an exhaustive sweep, all through a product scoreboard.
module tb_vedic_mult_8x8;
  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  logic [15:0] sb[$];

  vedic_mult_8x8_if bus ();

  vedic_mult_8x8 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_prod(input string tag, input logic [15:0] expected);
    tests_run++;
    assert (bus.prod === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: prod=%0d (0x%h) expected=%0d (0x%h)",
             tag, bus.prod, bus.prod, expected, expected);
    end
  endtask

  // Drive operands on the falling edge, capture on the rising edge,
  // and compare just after it against the scoreboard head.
  task automatic step(input string tag, input logic [7:0] av, input logic [7:0] bv);
    logic [15:0] exp_v;
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    sb.push_back(16'(av) * 16'(bv));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s: scoreboard empty, prod=%0d", tag, bus.prod);
    end else begin
      exp_v = sb.pop_front();
      check_prod(tag, exp_v);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.a = 8'd13;
    bus.b = 8'd11;

    // Reset held across several edges keeps prod at zero.
    repeat (3) @(posedge clk);
    #1;
    check_prod("reset_hold", 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(16'd143);
    @(posedge clk);
    #1;
    check_prod("reset_release", sb.pop_front());

    step("zero_x_ff",  8'h00, 8'hFF);
    step("ff_x_ff",    8'hFF, 8'hFF);
    step("80_x_02",    8'h80, 8'h02);
    step("one_x_a5",   8'h01, 8'hA5);
    step("0f_x_f0",    8'h0F, 8'hF0);

    step("b2b_3x5",     8'd3,   8'd5);
    step("b2b_200x100", 8'd200, 8'd100);
    step("b2b_17x17",   8'd17,  8'd17);

    step("carry_7f",    8'h7F, 8'h7F);
    step("carry_fe_ff", 8'hFE, 8'hFF);

    // Async reset between edges: prod clears before the next clock.
    step("pre_async", 8'd200, 8'd100);
    #2;
    rst_n = 1'b0;
    #1;
    check_prod("async_clear", 16'h0000);
    bus.a = 8'd9;
    bus.b = 8'd7;
    #1;
    rst_n = 1'b1;
    #0.5;
    check_prod("async_released_hold", 16'h0000);
    sb.push_back(16'd63);
    @(posedge clk);
    #1;
    check_prod("async_reload", sb.pop_front());

    for (int i = 0; i < 65536; i++) begin
      step("exhaustive", 8'(i >> 8), 8'(i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/vedic_mult_8x8.md
Name: vedic_mult_8x8

Overview:
- Unsigned 8x8 -> 16-bit multiplier built on the Vedic Urdhva-Tiryagbhyam (vertical-and-crosswise) decomposition, with a registered product output.
- Used as a single-cycle-latency multiply primitive in datapaths.
- It needs no handshake: a new operand pair can be presented every cycle.

Parameters:
- None. Widths are fixed: 8-bit operands, 16-bit product.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  8  multiplicand, unsigned.
- b  input  8  multiplier, unsigned.
- prod  output  16  registered product a*b, unsigned.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset:
  - rst_n low clears prod to 16'h0000 immediately, without waiting for a clock edge.
  - prod holds 0 while rst_n is low.
  - On the first rising edge of clk after rst_n deasserts, prod loads a*b of the operands present at that edge.
- Latency:
  - The combinational core computes a*b from the current a and b.
  - prod registers that result on every rising clk edge.
  - Operands stable before edge k appear on prod after edge k and are held until edge k+1.
  - Throughput is one product per cycle.
- Arithmetic:
  - Unsigned only. prod = a*b exactly, with no truncation or saturation.
  - The maximum result is 255*255 = 65025 (16'hFE01), which always fits in 16 bits.
  - There is no overflow flag.
- Required core structure (hierarchical Vedic decomposition):
  - 2x2 cell:
    - p0 = a0&b0.
    - Crosswise terms a1&b0 and a0&b1 go through a half adder.
    - Vertical term a1&b1 plus the carry go through a half adder.
    - Result is a 4-bit product.
  - 4x4 cell:
    - Four 2x2 cells on the operand nibble-halves: LL, LH, HL, HH.
    - Bits [1:0] = LL[1:0].
    - Middle sum = LH + HL + {2'b00, LL[3:2]}, computed with ripple or carry-save adders.
    - Upper = HH + carry-out of the middle sum.
    - Result is 8 bits.
  - 8x8 cell: the same pattern using four 4x4 cells on the byte-halves, giving 16 bits.
  - The core must be purely combinational: no latches, and no `*` operator in the core.
  - The final register is the only state element.
- Boundary conditions:
  - a=0 or b=0 gives prod=0.
  - a=1 gives prod=b.
  - Every bit of every adder carry must be propagated; results must match a*b for all 65536 operand pairs.
- Reset mid-operation: asserting rst_n at any time forces prod=0 asynchronously and discards the pending product. No stale value appears after release.
- X-handling: there is no internal state other than prod, so an X on an input affects only the next registered value.

Test Plan:
- Reset: hold rst_n=0 with a=8'd13, b=8'd11, clocking -> prod=0. Release rst_n -> after the next rising edge prod=143 (16'h008F).
- Corners, one per cycle, each checked one cycle after applying:
  - 0x00*0xFF -> 0.
  - 0xFF*0xFF -> 65025 (16'hFE01).
  - 0x80*0x02 -> 256 (16'h0100).
  - 0x01*0xA5 -> 165.
  - 0x0F*0xF0 -> 3600 (16'h0E10).
- Back-to-back throughput: apply 3*5, 200*100, 17*17 on consecutive edges -> prod = 15, 20000, 289 on consecutive cycles, with no bubbles.
- Asynchronous reset mid-stream: with prod=20000, pulse rst_n low between clock edges -> prod goes to 0 before the next edge. After release, the next edge loads the current a*b.
- Exhaustive/random check: all 65536 (a,b) pairs, or at least 10,000 random pairs including zeros, each compared against a reference a*b one cycle after it is applied -> zero mismatches.
- Carry stress: a=b=0x7F -> 16129 (16'h3F01); a=0xFE, b=0xFF -> 64770 (16'hFD02).
